// File: rtl/rf_bank_arbiter.sv
// Four-bank operand register file with one request FIFO per bank.
// Requests carry up to two operands (A and B). Each operand is queued as
// {row, ocid} on the FIFO of its bank. Every bank that has a queued entry
// and no writeback this cycle pops one entry. The row is read with one cycle
// of latency and returned on bk_n_data / bk_n_ocid with bk_n_vld set.
module rf_bank_arbiter #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_en,
    input  logic          req_a_vld,
    input  logic          req_b_vld,
    input  logic [2:0]    rowid_a,
    input  logic [2:0]    rowid_b,
    input  logic [1:0]    bankid_a,
    input  logic [1:0]    bankid_b,
    input  logic [1:0]    req_ocid,
    input  logic          wb_en,
    input  logic [1:0]    wb_bank,
    input  logic [2:0]    wb_row,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] bk_0_data,
    output logic          bk_0_vld,
    output logic [1:0]    bk_0_ocid,
    output logic          bk_0_bz,
    output logic [DW-1:0] bk_1_data,
    output logic          bk_1_vld,
    output logic [1:0]    bk_1_ocid,
    output logic          bk_1_bz,
    output logic [DW-1:0] bk_2_data,
    output logic          bk_2_vld,
    output logic [1:0]    bk_2_ocid,
    output logic          bk_2_bz,
    output logic [DW-1:0] bk_3_data,
    output logic          bk_3_vld,
    output logic [1:0]    bk_3_ocid,
    output logic          bk_3_bz,
    output logic          req_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [4:0] entry_t;   // {row[2:0], ocid[1:0]}

    logic [DW-1:0] mem_q     [4][8];
    logic [DW-1:0] mem_d     [4][8];
    entry_t        fifo_q    [4][DEPTH];
    entry_t        fifo_d    [4][DEPTH];
    logic [PW-1:0] rd_ptr_q  [4];
    logic [PW-1:0] rd_ptr_d  [4];
    logic [PW-1:0] wr_ptr_q  [4];
    logic [PW-1:0] wr_ptr_d  [4];
    logic [CW-1:0] cnt_q     [4];
    logic [CW-1:0] cnt_d     [4];
    logic [DW-1:0] bk_data_q [4];
    logic [DW-1:0] bk_data_d [4];
    logic [1:0]    bk_ocid_q [4];
    logic [1:0]    bk_ocid_d [4];
    logic [3:0]    bk_vld_q;
    logic [3:0]    bk_vld_d;
    logic          req_err_q;
    logic          req_err_d;

    logic          push_a    [4];
    logic          push_b    [4];
    logic [1:0]    n_push    [4];
    logic [3:0]    lack;
    logic [3:0]    pop;
    logic [3:0]    bz;
    logic          accept;

    // Decode which banks this request targets; reject the whole request if any bank cannot take all its entries.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            push_a[n] = req_a_vld && (bankid_a == 2'(n));
            push_b[n] = req_b_vld && (bankid_b == 2'(n));
            n_push[n] = {1'b0, push_a[n]} + {1'b0, push_b[n]};
            lack[n]   = ((CW+1)'(cnt_q[n]) + (CW+1)'(n_push[n])) > (CW+1)'(DEPTH);
        end
        accept    = req_en && (lack == 4'b0000);
        req_err_d = req_err_q || (req_en && (lack != 4'b0000));
    end

    // Register writeback; a bank being written does not pop, so reads never collide with writes.
    always_comb begin
        mem_d = mem_q;
        if (wb_en) begin
            mem_d[wb_bank][wb_row] = wb_data;
        end
    end

    // Per-bank pop/read of the FIFO head and push of accepted operands (A before B).
    always_comb begin
        entry_t        head;
        logic [PW-1:0] wr;
        fifo_d    = fifo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        bk_data_d = bk_data_q;
        bk_ocid_d = bk_ocid_q;
        bk_vld_d  = 4'b0000;
        pop       = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            head   = fifo_q[n][rd_ptr_q[n]];
            pop[n] = (cnt_q[n] != '0) && !(wb_en && (wb_bank == 2'(n)));
            if (pop[n]) begin
                bk_vld_d[n]  = 1'b1;
                bk_data_d[n] = mem_q[n][head[4:2]];
                bk_ocid_d[n] = head[1:0];
                rd_ptr_d[n]  = rd_ptr_q[n] + 1'b1;
            end
            wr = wr_ptr_q[n];
            if (accept && push_a[n]) begin
                fifo_d[n][wr] = {rowid_a, req_ocid};
                wr            = wr + 1'b1;
            end
            if (accept && push_b[n]) begin
                fifo_d[n][wr] = {rowid_b, req_ocid};
                wr            = wr + 1'b1;
            end
            wr_ptr_d[n] = wr;
            cnt_d[n]    = cnt_q[n] + (accept ? CW'(n_push[n]) : CW'(0)) - CW'(pop[n]);
        end
    end

    // Busy when fewer than two slots remain, so a two-operand request always fits while busy is low.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            bz[n] = cnt_q[n] > CW'(DEPTH - 2);
        end
    end

    // State registers; reset clears storage, queues and returned data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q     <= '{default: '0};
            fifo_q    <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
            wr_ptr_q  <= '{default: '0};
            cnt_q     <= '{default: '0};
            bk_data_q <= '{default: '0};
            bk_ocid_q <= '{default: '0};
            bk_vld_q  <= 4'b0000;
            req_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            bk_data_q <= bk_data_d;
            bk_ocid_q <= bk_ocid_d;
            bk_vld_q  <= bk_vld_d;
            req_err_q <= req_err_d;
        end
    end

    assign bk_0_data = bk_data_q[0];
    assign bk_1_data = bk_data_q[1];
    assign bk_2_data = bk_data_q[2];
    assign bk_3_data = bk_data_q[3];
    assign bk_0_ocid = bk_ocid_q[0];
    assign bk_1_ocid = bk_ocid_q[1];
    assign bk_2_ocid = bk_ocid_q[2];
    assign bk_3_ocid = bk_ocid_q[3];
    assign bk_0_vld  = bk_vld_q[0];
    assign bk_1_vld  = bk_vld_q[1];
    assign bk_2_vld  = bk_vld_q[2];
    assign bk_3_vld  = bk_vld_q[3];
    assign bk_0_bz   = bz[0];
    assign bk_1_bz   = bz[1];
    assign bk_2_bz   = bz[2];
    assign bk_3_bz   = bz[3];
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Bench for rf_bank_arbiter: directed scenarios plus randomized traffic,
// checked by a queue-level reference model and a decoupled output monitor.
module tb_rf_bank_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_en, req_a_vld, req_b_vld;
    logic [2:0]    rowid_a, rowid_b;
    logic [1:0]    bankid_a, bankid_b, req_ocid;
    logic          wb_en;
    logic [1:0]    wb_bank;
    logic [2:0]    wb_row;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] bk_data [4];
    logic          bk_vld  [4];
    logic [1:0]    bk_ocid [4];
    logic          bk_bz   [4];
    logic          req_err;

    always #5 clk = ~clk;

    rf_bank_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_a_vld(req_a_vld), .req_b_vld(req_b_vld),
        .rowid_a(rowid_a), .rowid_b(rowid_b), .bankid_a(bankid_a), .bankid_b(bankid_b),
        .req_ocid(req_ocid),
        .wb_en(wb_en), .wb_bank(wb_bank), .wb_row(wb_row), .wb_data(wb_data),
        .bk_0_data(bk_data[0]), .bk_0_vld(bk_vld[0]), .bk_0_ocid(bk_ocid[0]), .bk_0_bz(bk_bz[0]),
        .bk_1_data(bk_data[1]), .bk_1_vld(bk_vld[1]), .bk_1_ocid(bk_ocid[1]), .bk_1_bz(bk_bz[1]),
        .bk_2_data(bk_data[2]), .bk_2_vld(bk_vld[2]), .bk_2_ocid(bk_ocid[2]), .bk_2_bz(bk_bz[2]),
        .bk_3_data(bk_data[3]), .bk_3_vld(bk_vld[3]), .bk_3_ocid(bk_ocid[3]), .bk_3_bz(bk_bz[3]),
        .req_err(req_err)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW+1:0] exp_q    [4][$];   // expected {data, ocid} per bank, in return order
    logic [4:0]    mdl_fifo [4][$];   // pending {row, ocid} per bank
    logic [DW-1:0] mdl_mem  [4][8];
    logic          mdl_err;
    logic [DW-1:0] last_data [4];
    logic [1:0]    last_ocid [4];
    logic [DW+1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            exp_q[b].delete();
            mdl_fifo[b].delete();
            last_data[b] = '0;
            last_ocid[b] = '0;
            for (int r = 0; r < 8; r++) mdl_mem[b][r] = '0;
        end
        mdl_err = 1'b0;
    endtask

    // One clock of the reference: admission on current occupancy, one service per
    // non-written bank using memory as it stands, then the write, then the pushes.
    task automatic model_step();
        int       np [4];
        bit       acc;
        bit [4:0] e;
        for (int b = 0; b < 4; b++)
            np[b] = int'(req_a_vld && bankid_a == 2'(b)) + int'(req_b_vld && bankid_b == 2'(b));
        acc = req_en;
        for (int b = 0; b < 4; b++)
            if (mdl_fifo[b].size() + np[b] > DEPTH) acc = 1'b0;
        if (req_en && !acc) mdl_err = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (mdl_fifo[b].size() > 0 && !(wb_en && wb_bank == 2'(b))) begin
                e = mdl_fifo[b].pop_front();
                exp_q[b].push_back({mdl_mem[b][e[4:2]], e[1:0]});
            end
        end
        if (wb_en) mdl_mem[wb_bank][wb_row] = wb_data;
        if (acc) begin
            if (req_a_vld) mdl_fifo[bankid_a].push_back({rowid_a, req_ocid});
            if (req_b_vld) mdl_fifo[bankid_b].push_back({rowid_b, req_ocid});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
        for (int b = 0; b < 4; b++)
            chk($sformatf("bz%0d", b), bk_bz[b], mdl_fifo[b].size() > DEPTH - 2);
        chk("req_err", req_err, mdl_err);
    endtask

    task automatic idle();
        req_en = 0; req_a_vld = 0; req_b_vld = 0;
        rowid_a = 0; rowid_b = 0; bankid_a = 0; bankid_b = 0; req_ocid = 0;
        wb_en = 0; wb_bank = 0; wb_row = 0; wb_data = '0;
    endtask

    task automatic set_req(input logic av, input logic [2:0] ra, input logic [1:0] ba,
                           input logic bv, input logic [2:0] rb, input logic [1:0] bb,
                           input logic [1:0] oc);
        req_en = 1; req_a_vld = av; rowid_a = ra; bankid_a = ba;
        req_b_vld = bv; rowid_b = rb; bankid_b = bb; req_ocid = oc;
    endtask

    task automatic set_wb(input logic [1:0] bank, input logic [2:0] row, input logic [DW-1:0] data);
        wb_en = 1; wb_bank = bank; wb_row = row; wb_data = data;
    endtask

    function automatic int pending();
        int s = 0;
        for (int b = 0; b < 4; b++) s += mdl_fifo[b].size() + exp_q[b].size();
        return s;
    endfunction

    // Monitor: every returned value must match the next expected one for that bank;
    // while idle, data and ocid must hold the last returned value.
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bk_vld[b]) begin
                if (exp_q[b].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_vld bank%0d: actual vld=1 required vld=0", b);
                end else begin
                    mon_e = exp_q[b].pop_front();
                    chk($sformatf("data%0d", b), bk_data[b], mon_e[DW+1:2]);
                    chk($sformatf("ocid%0d", b), bk_ocid[b], mon_e[1:0]);
                    last_data[b] = mon_e[DW+1:2];
                    last_ocid[b] = mon_e[1:0];
                end
            end else begin
                chk($sformatf("hold_data%0d", b), bk_data[b], last_data[b]);
                chk($sformatf("hold_ocid%0d", b), bk_ocid[b], last_ocid[b]);
            end
        end
    end

    initial begin
        bit       av, bv;
        bit [1:0] ba, bb;
        rst = 1'b0;
        idle();
        model_reset();
        #12;
        for (int b = 0; b < 4; b++) begin
            chk("rst_vld", bk_vld[b], 1'b0);
            chk("rst_data", bk_data[b], 0);
            chk("rst_ocid", bk_ocid[b], 0);
            chk("rst_bz", bk_bz[b], 1'b0);
        end
        chk("rst_err", req_err, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;

        // Write then read, two-cycle latency, single-cycle valid
        set_wb(1, 5, 32'hDEADBEEF); step();
        idle(); set_req(1, 5, 1, 0, 0, 0, 2); step();
        chk("lat_early_vld1", bk_vld[1], 1'b0);
        idle(); step();
        chk("lat_vld1", bk_vld[1], 1'b1);
        chk("lat_data1", bk_data[1], 32'hDEADBEEF);
        chk("lat_ocid1", bk_ocid[1], 2);
        step();
        chk("lat_vld1_drop", bk_vld[1], 1'b0);

        // A and B on the same bank come back in order on consecutive cycles
        set_wb(2, 0, 32'hA0); step();
        set_wb(2, 3, 32'hA3); step();
        idle(); set_req(1, 0, 2, 1, 3, 2, 1); step();
        idle(); step();
        chk("ab_vld_a", bk_vld[2], 1'b1);
        chk("ab_data_a", bk_data[2], 32'hA0);
        chk("ab_ocid_a", bk_ocid[2], 1);
        step();
        chk("ab_vld_b", bk_vld[2], 1'b1);
        chk("ab_data_b", bk_data[2], 32'hA3);
        chk("ab_ocid_b", bk_ocid[2], 1);
        step();
        chk("ab_vld_end", bk_vld[2], 1'b0);

        // Write and request to the same row in one cycle returns the new data
        idle(); set_wb(3, 2, 32'h11); set_req(1, 2, 3, 0, 0, 0, 3); step();
        idle(); step();
        chk("wbr_vld3", bk_vld[3], 1'b1);
        chk("wbr_data3", bk_data[3], 32'h11);

        // Continuous writeback stalls bank0; fill to 3, then a two-operand request is rejected
        for (int i = 0; i < 3; i++) begin
            idle(); set_wb(0, 7, $urandom); set_req(1, 3'(i + 1), 0, 0, 0, 0, 2'(i)); step();
            chk("fill_bz0", bk_bz[0], i == 2);
        end
        idle(); set_wb(0, 6, $urandom); set_req(1, 4, 0, 1, 5, 0, 3); step();
        chk("reject_err", req_err, 1'b1);
        chk("reject_bz0", bk_bz[0], 1'b1);
        idle();
        repeat (5) step();
        chk("reject_err_sticky", req_err, 1'b1);

        // Reset in the middle of draining all four banks
        set_req(1, 1, 0, 1, 2, 1, 0); step();
        set_req(1, 3, 2, 1, 4, 3, 1); step();
        set_req(1, 5, 0, 1, 6, 1, 2); step();
        set_req(1, 7, 2, 1, 0, 3, 3); step();
        idle(); step();
        rst = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            chk("mid_rst_vld", bk_vld[b], 1'b0);
            chk("mid_rst_data", bk_data[b], 0);
            chk("mid_rst_ocid", bk_ocid[b], 0);
            chk("mid_rst_bz", bk_bz[b], 1'b0);
        end
        chk("mid_rst_err", req_err, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        step();
        for (int b = 0; b < 4; b++) chk("post_rst_vld", bk_vld[b], 1'b0);
        repeat (5) step();

        // Randomized traffic, requests only to banks that are not busy
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(9) < 3) set_wb(2'($urandom), 3'($urandom), $urandom);
            if ($urandom_range(9) < 6) begin
                av = 1'($urandom); bv = 1'($urandom);
                ba = 2'($urandom); bb = 2'($urandom);
                if (!((av && mdl_fifo[ba].size() > DEPTH - 2) || (bv && mdl_fifo[bb].size() > DEPTH - 2)))
                    set_req(av, 3'($urandom), ba, bv, 3'($urandom), bb, 2'($urandom));
            end
            step();
        end

        // Drain with a bounded budget
        idle();
        for (int i = 0; i < 200; i++) begin
            if (pending() == 0) break;
            step();
            @(negedge clk); #1;
        end
        chk("drain_pending", pending(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_bank_arbiter.md
RF_BANK_ARBITER -- requirements
Module: rf_bank_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning per-bank request FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_en, input, 1: operand request strobe from operand issue (ReqFIFO_2op_EN).
REQ-006 SHALL have ports req_a_vld / req_b_vld, input, 1 each: operand A / B present in this request.
REQ-007 SHALL have ports rowid_a, rowid_b, input, 3 each, and bankid_a, bankid_b, input, 2 each: operand row and bank.
REQ-008 SHALL have port req_ocid, input, 2: destination collector unit id.
REQ-009 SHALL have ports wb_en input 1, wb_bank input 2, wb_row input 3, wb_data input DW: register writeback.
REQ-010 SHALL have, per bank n=0..3, outputs bk_n_data DW, bk_n_vld 1, bk_n_ocid 2, bk_n_bz 1.
REQ-011 SHALL have output req_err, 1: sticky flag, request issued while rejected.

Function
REQ-012 SHALL hold 4 banks x 8 rows x DW register storage, plus one DEPTH-entry FIFO per bank; entry = {row[2:0], ocid[1:0]}.
REQ-013 SHALL accept a request when req_en=1 and no targeted bank lacks free slots for all entries pushed to it this cycle.
REQ-014 On acceptance SHALL push A to FIFO[bankid_a] if req_a_vld, B to FIFO[bankid_b] if req_b_vld; A and B to same bank push 2 entries, A first.
REQ-015 On rejection SHALL push nothing (neither operand) and set req_err; req_err clears only on reset.
REQ-016 bk_n_bz SHALL be combinational: 1 when FIFO n has fewer than 2 free entries (count > DEPTH-2).
REQ-017 Each cycle each bank with non-empty FIFO and no same-bank write SHALL pop head and read row; read has 1-cycle latency.
REQ-018 Cycle after a pop, bk_n_vld SHALL be 1 with bk_n_data = row contents and bk_n_ocid = entry ocid; else bk_n_vld=0, data/ocid hold last value.
REQ-019 wb_en SHALL write wb_data to [wb_bank][wb_row] at clock edge; write has priority, that bank pops nothing that cycle.
REQ-020 A read popped the cycle after a write to the same row SHALL return the written data (no stale read).
REQ-021 Same-cycle push into empty FIFO SHALL NOT pop that cycle; minimum request-to-bk_vld latency is 2 cycles.
REQ-022 Simultaneous push and pop on one FIFO SHALL leave count +pushes-1; count SHALL never exceed DEPTH nor underflow.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; order per bank strictly FIFO.
REQ-024 Banks SHALL operate independently; up to 4 bk_vld asserted in one cycle.
REQ-025 req_en=1 with both req_a_vld and req_b_vld 0 SHALL be a no-op, not an error.

Reset
REQ-026 rst low SHALL immediately clear all FIFOs (count 0, pointers 0), all bk_n_vld, bk_n_data, bk_n_ocid, bk_n_bz, req_err and every register row to 0.
REQ-027 Reset mid-operation SHALL discard in-flight requests and pending read results; no bk_vld in the cycle after rst deasserts.

Verification
REQ-028 Write 0xDEADBEEF to bank1 row5, then request A=(row5,bank1), ocid=2 -> two cycles later bk_1_vld=1, bk_1_data=0xDEADBEEF, bk_1_ocid=2, for one cycle.
REQ-029 A=(row0,bank2), B=(row3,bank2), ocid=1 -> bk_2_vld high two consecutive cycles, row0 data then row3 data, ocid 1 both.
REQ-030 Keep wb_en=1 to bank0 while issuing 3 requests to bank0 (DEPTH=4) -> bk_0_bz=1 after count reaches 3; 4th request with A and B to bank0 rejected, req_err=1, count stays 3.
REQ-031 Write row2 bank3 = 0x11, same cycle request read row2 bank3 -> returned data 0x11 (write-before-read).
REQ-032 Fill all 4 banks, assert rst low mid-drain -> all outputs 0 immediately; after release, no bk_vld until new requests.
REQ-033 Random issue/writeback, requests only when targeted bk_bz=0 -> every request returns exactly once, per-bank order preserved, data matches reference model, req_err stays 0.
